// File: rtl/usb_ctrl_ep_rx_pkg.sv
// rtl/usb_ctrl_ep_rx_pkg.sv - shared USB control-transfer constants, stage encoding and SETUP layout
package usbSpec;

    localparam logic [7:0] BREQUEST_GET_STATUS        = 8'h00;
    localparam logic [7:0] BREQUEST_CLEAR_FEATURE     = 8'h01;
    localparam logic [7:0] BREQUEST_SET_ADDRESS       = 8'h05;
    localparam logic [7:0] BREQUEST_GET_DESCRIPTOR    = 8'h06;
    localparam logic [7:0] BREQUEST_GET_CONFIGURATION = 8'h08;
    localparam logic [7:0] BREQUEST_SET_CONFIGURATION = 8'h09;
    localparam logic [7:0] BREQUEST_SYNCH_FRAME       = 8'h0C;

    localparam int         BMRT_DIR_BIT       = 7;
    localparam int         BMRT_TYPE_MSB      = 6;
    localparam int         BMRT_TYPE_LSB      = 5;
    localparam logic [1:0] BMRT_TYPE_STANDARD = 2'd0;

    localparam logic [2:0] STAGE_IDLE       = 3'd0;
    localparam logic [2:0] STAGE_DATA_OUT   = 3'd1;
    localparam logic [2:0] STAGE_DATA_IN    = 3'd2;
    localparam logic [2:0] STAGE_STATUS_OUT = 3'd3;
    localparam logic [2:0] STAGE_STATUS_IN  = 3'd4;
    localparam logic [2:0] STAGE_STALLED    = 3'd5;

    localparam logic [2:0] TXN_SETUP = 3'b100;
    localparam logic [2:0] TXN_OUT   = 3'b010;
    localparam logic [2:0] TXN_IN    = 3'b001;

    // Little-endian SETUP payload: byte 0 (bmRequestType) sits in bits [7:0].
    typedef struct packed {
        logic [15:0] wLength;
        logic [15:0] wIndex;
        logic [15:0] wValue;
        logic [7:0]  bRequest;
        logic [7:0]  bmRequestType;
    } setupPkt_t;

    function automatic logic isSupportedStd(input logic [7:0] bRequest);
        case (bRequest)
            BREQUEST_GET_STATUS, BREQUEST_CLEAR_FEATURE, BREQUEST_SET_ADDRESS,
            BREQUEST_GET_DESCRIPTOR, BREQUEST_GET_CONFIGURATION,
            BREQUEST_SET_CONFIGURATION: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/usb_ctrl_ep_rx_if.sv
// rtl/usb_ctrl_ep_rx_if.sv - endpoint-receive handshake between transaction layer and EP0
interface usb_ctrl_ep_rx_if #(parameter int MAX_PKT = 8);
    localparam int NBW = $clog2(MAX_PKT) + 1;

    logic                   erReady;
    logic                   erValid;
    logic                   erStall;
    logic [8*MAX_PKT-1:0]   erData;
    logic [NBW-1:0]         erData_nBytes;
    logic [2:0]             txnType;

    modport master (input erReady, erStall, output erValid, erData, erData_nBytes, txnType);
    modport slave  (output erReady, erStall, input erValid, erData, erData_nBytes, txnType);
endinterface

// File: rtl/usb_ctrl_skid1.sv
// rtl/usb_ctrl_skid1.sv - single-entry valid/ready holding buffer; a load wins over a same-cycle drain
module usb_ctrl_skid1 #(parameter int WIDTH = 8) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inValid,
    output logic             o_inReady,
    input  logic [WIDTH-1:0] i_inData,
    output logic             o_outValid,
    input  logic             i_outReady,
    output logic [WIDTH-1:0] o_outData
);
    assign o_inReady = !o_outValid || i_outReady;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_outValid <= 1'b0;
            o_outData  <= '0;
        end else if (i_inValid) begin
            o_outValid <= 1'b1;
            o_outData  <= i_inData;
        end else if (i_outReady) begin
            o_outValid <= 1'b0;
        end
    end
endmodule

// File: rtl/usb_ctrl_ep_rx.sv
// rtl/usb_ctrl_ep_rx.sv - EP0 receive stage: SETUP decode, control-stage tracking, OUT buffering, STALL
module usb_ctrl_ep_rx
    import usbSpec::*;
#(
    parameter int MAX_PKT = 8,
    localparam int NBW    = $clog2(MAX_PKT) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    usb_ctrl_ep_rx_if.slave      er,
    output logic                 o_reqValid,
    output logic [7:0]           o_bmRequestType,
    output logic [7:0]           o_bRequest,
    output logic [15:0]          o_wValue,
    output logic [15:0]          o_wIndex,
    output logic [15:0]          o_wLength,
    output logic [2:0]           o_stage,
    output logic                 o_outValid,
    input  logic                 i_outReady,
    output logic [8*MAX_PKT-1:0] o_outData,
    output logic [NBW-1:0]       o_outData_nBytes,
    output logic [6:0]           o_addr,
    output logic [7:0]           o_cfg
);
    logic [2:0]  stage;
    logic [15:0] remaining;
    logic [6:0]  pendAddr;
    logic        pendValid;

    logic        isSetup, isOut, isIn, accept, readyRaw, stallRaw, bufReady, bufLoad;
    logic        overrun, shortPkt, isStd;
    logic [15:0] nBytes16, newRemaining;
    setupPkt_t   setup;

    assign isSetup = (er.txnType == TXN_SETUP);
    assign isOut   = (er.txnType == TXN_OUT);
    assign isIn    = (er.txnType == TXN_IN);
    assign setup   = setupPkt_t'(er.erData[63:0]);
    assign isStd   = (setup.bmRequestType[BMRT_TYPE_MSB:BMRT_TYPE_LSB] == BMRT_TYPE_STANDARD);

    assign nBytes16     = 16'(er.erData_nBytes);
    assign overrun      = (nBytes16 > remaining);
    assign newRemaining = overrun ? 16'd0 : (remaining - nBytes16);
    assign shortPkt     = (nBytes16 < 16'(MAX_PKT));

    always_comb begin
        readyRaw = 1'b1;
        if (!er.txnType[2] && isOut && stage == STAGE_DATA_OUT)
            readyRaw = bufReady;
    end

    // A zero-length OUT during DATA_IN is the host ending the transfer early, not an error.
    always_comb begin
        stallRaw = 1'b0;
        if (isOut)
            stallRaw = !(stage == STAGE_DATA_OUT || stage == STAGE_STATUS_OUT ||
                         (stage == STAGE_DATA_IN && nBytes16 == 16'd0)) ||
                       (stage == STAGE_STATUS_OUT && nBytes16 != 16'd0);
        else if (isIn)
            stallRaw = !(stage == STAGE_DATA_IN || stage == STAGE_STATUS_IN);
    end

    // Handshake outputs read as 0 while reset is held, like every registered output.
    assign er.erReady = i_rst && readyRaw;
    assign er.erStall = i_rst && stallRaw;
    assign accept     = er.erReady && er.erValid;
    assign bufLoad    = accept && isOut && stage == STAGE_DATA_OUT;
    assign o_stage    = stage;

    usb_ctrl_skid1 #(.WIDTH(8*MAX_PKT + NBW)) u_buf (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inValid  (bufLoad),
        .o_inReady  (bufReady),
        .i_inData   ({er.erData_nBytes, er.erData}),
        .o_outValid (o_outValid),
        .i_outReady (i_outReady),
        .o_outData  ({o_outData_nBytes, o_outData})
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            stage           <= STAGE_IDLE;
            remaining       <= '0;
            pendAddr        <= '0;
            pendValid       <= 1'b0;
            o_reqValid      <= 1'b0;
            o_bmRequestType <= '0;
            o_bRequest      <= '0;
            o_wValue        <= '0;
            o_wIndex        <= '0;
            o_wLength       <= '0;
            o_addr          <= '0;
            o_cfg           <= '0;
        end else begin
            o_reqValid <= 1'b0;
            if (accept) begin
                if (isSetup) begin
                    pendValid <= 1'b0;
                    remaining <= '0;
                    if (er.erData_nBytes != NBW'(8)) begin
                        stage <= STAGE_STALLED;
                    end else begin
                        o_bmRequestType <= setup.bmRequestType;
                        o_bRequest      <= setup.bRequest;
                        o_wValue        <= setup.wValue;
                        o_wIndex        <= setup.wIndex;
                        o_wLength       <= setup.wLength;
                        if (isStd && !isSupportedStd(setup.bRequest)) begin
                            stage <= STAGE_STALLED;
                        end else begin
                            o_reqValid <= 1'b1;
                            remaining  <= setup.wLength;
                            if (setup.wLength == 16'd0)
                                stage <= STAGE_STATUS_IN;
                            else if (setup.bmRequestType[BMRT_DIR_BIT])
                                stage <= STAGE_DATA_IN;
                            else
                                stage <= STAGE_DATA_OUT;
                            if (isStd && setup.bRequest == BREQUEST_SET_ADDRESS) begin
                                pendAddr  <= setup.wValue[6:0];
                                pendValid <= 1'b1;
                            end
                            if (isStd && setup.bRequest == BREQUEST_SET_CONFIGURATION)
                                o_cfg <= setup.wValue[7:0];
                        end
                    end
                end else if (stallRaw) begin
                    stage <= STAGE_STALLED;
                end else if (isOut) begin
                    if (stage == STAGE_DATA_OUT) begin
                        remaining <= newRemaining;
                        if (overrun)
                            stage <= STAGE_STALLED;
                        else if (newRemaining == 16'd0 || shortPkt)
                            stage <= STAGE_STATUS_IN;
                    end else begin
                        stage <= STAGE_IDLE;
                    end
                end else if (isIn) begin
                    if (stage == STAGE_DATA_IN) begin
                        remaining <= newRemaining;
                        if (newRemaining == 16'd0 || shortPkt)
                            stage <= STAGE_STATUS_OUT;
                    end else begin
                        stage <= STAGE_IDLE;
                        if (pendValid) begin
                            o_addr    <= pendAddr;
                            pendValid <= 1'b0;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_ctrl_ep_rx.sv
// tb/tb_usb_ctrl_ep_rx.sv - self-checking bench for the EP0 receive stage
module tb_usb_ctrl_ep_rx;
    import usbSpec::*;

    localparam int MAX_PKT = 8;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 i_clk = ~i_clk;

    usb_ctrl_ep_rx_if #(.MAX_PKT(MAX_PKT)) erIf ();

    logic        o_reqValid;
    logic [7:0]  o_bmRequestType, o_bRequest, o_cfg;
    logic [15:0] o_wValue, o_wIndex, o_wLength;
    logic [2:0]  o_stage;
    logic        o_outValid;
    logic        outReady;
    logic [63:0] o_outData;
    logic [3:0]  o_outData_nBytes;
    logic [6:0]  o_addr;

    usb_ctrl_ep_rx #(.MAX_PKT(MAX_PKT)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .er               (erIf),
        .o_reqValid       (o_reqValid),
        .o_bmRequestType  (o_bmRequestType),
        .o_bRequest       (o_bRequest),
        .o_wValue         (o_wValue),
        .o_wIndex         (o_wIndex),
        .o_wLength        (o_wLength),
        .o_stage          (o_stage),
        .o_outValid       (o_outValid),
        .i_outReady       (outReady),
        .o_outData        (o_outData),
        .o_outData_nBytes (o_outData_nBytes),
        .o_addr           (o_addr),
        .o_cfg            (o_cfg)
    );

    typedef struct {
        logic [63:0] data;
        logic [3:0]  nBytes;
    } pkt_t;

    typedef struct {
        string       name;
        logic [2:0]  txn;
        logic [3:0]  nb;
        logic [63:0] data;
        logic        expStall;
        logic [2:0]  expStage;
        logic        expReq;
        logic [6:0]  expAddr;
        logic        push;
    } step_t;

    pkt_t  sbQ[$];
    step_t steps[$];
    int    checks   = 0;
    int    failures = 0;
    bit    monEn    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sp(input logic [7:0] bm, input logic [7:0] br,
                                       input logic [15:0] wv, input logic [15:0] wi,
                                       input logic [15:0] wl);
        return {wl, wi, wv, br, bm};
    endfunction

    function automatic step_t mk(input string name, input logic [2:0] txn, input logic [3:0] nb,
                                 input logic [63:0] data, input logic expStall,
                                 input logic [2:0] expStage, input logic expReq,
                                 input logic [6:0] expAddr, input logic push);
        step_t s;
        s.name = name; s.txn = txn; s.nb = nb; s.data = data; s.expStall = expStall;
        s.expStage = expStage; s.expReq = expReq; s.expAddr = expAddr; s.push = push;
        return s;
    endfunction

    // Sink scoreboard: each cycle with valid and ready high drains one packet at the next edge.
    always @(negedge i_clk) begin
        pkt_t e;
        if (monEn && o_outValid && outReady) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sinkUnexpected actual=%0h required=none", o_outData);
            end else begin
                e = sbQ.pop_front();
                check("sinkData", o_outData, e.data);
                check("sinkBytes", 64'(o_outData_nBytes), 64'(e.nBytes));
            end
        end
    end

    task automatic doTxn(input string name, input logic [2:0] txn, input logic [3:0] nb,
                         input logic [63:0] data, input logic expStall, input logic push,
                         output int waited);
        pkt_t p;
        waited = 0;
        @(posedge i_clk); #1;
        erIf.erValid       = 1'b1;
        erIf.txnType       = txn;
        erIf.erData_nBytes = nb;
        erIf.erData        = data;
        @(negedge i_clk);
        while (!erIf.erReady && waited < 40) begin
            @(negedge i_clk);
            waited++;
        end
        if (!erIf.erReady) begin
            checks++;
            failures++;
            $display("FAIL %s.readyTimeout actual=0 required=1", name);
            erIf.erValid = 1'b0;
            return;
        end
        check({name, ".stall"}, 64'(erIf.erStall), 64'(expStall));
        if (push) begin
            p.data = data;
            p.nBytes = nb;
            sbQ.push_back(p);
        end
        @(posedge i_clk); #1;
        erIf.erValid = 1'b0;
        @(negedge i_clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int w;
        erIf.erValid = 1'b0; erIf.txnType = 3'b000; erIf.erData_nBytes = '0; erIf.erData = '0;
        outReady = 1'b1;
        #12;
        check("rst.stage", 64'(o_stage), 64'(STAGE_IDLE));
        check("rst.ready", 64'(erIf.erReady), 64'd0);
        check("rst.outValid", 64'(o_outValid), 64'd0);
        check("rst.addrCfg", 64'({o_addr, o_cfg}), 64'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        monEn = 1'b1;

        steps.push_back(mk("t1setup", TXN_SETUP, 4'd8, sp(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0012), 1'b0, STAGE_DATA_IN, 1'b1, 7'h00, 1'b0));
        steps.push_back(mk("t1in8a", TXN_IN, 4'd8, 64'h0, 1'b0, STAGE_DATA_IN, 1'b0, 7'h00, 1'b0));
        steps.push_back(mk("t1in8b", TXN_IN, 4'd8, 64'h0, 1'b0, STAGE_DATA_IN, 1'b0, 7'h00, 1'b0));
        steps.push_back(mk("t1in2", TXN_IN, 4'd2, 64'h0, 1'b0, STAGE_STATUS_OUT, 1'b0, 7'h00, 1'b0));
        steps.push_back(mk("t1status", TXN_OUT, 4'd0, 64'h0, 1'b0, STAGE_IDLE, 1'b0, 7'h00, 1'b0));
        steps.push_back(mk("t2setAddr", TXN_SETUP, 4'd8, sp(8'h00, 8'h05, 16'h002A, 16'h0000, 16'h0000), 1'b0, STAGE_STATUS_IN, 1'b1, 7'h00, 1'b0));
        steps.push_back(mk("t2statusIn", TXN_IN, 4'd0, 64'h0, 1'b0, STAGE_IDLE, 1'b0, 7'h2A, 1'b0));
        steps.push_back(mk("t4synch", TXN_SETUP, 4'd8, sp(8'h82, 8'h0C, 16'h0000, 16'h0000, 16'h0002), 1'b0, STAGE_STALLED, 1'b0, 7'h2A, 1'b0));
        steps.push_back(mk("t4out", TXN_OUT, 4'd0, 64'h0, 1'b1, STAGE_STALLED, 1'b0, 7'h2A, 1'b0));
        steps.push_back(mk("t4in", TXN_IN, 4'd0, 64'h0, 1'b1, STAGE_STALLED, 1'b0, 7'h2A, 1'b0));
        steps.push_back(mk("t4recover", TXN_SETUP, 4'd8, sp(8'h80, 8'h08, 16'h0000, 16'h0000, 16'h0001), 1'b0, STAGE_DATA_IN, 1'b1, 7'h2A, 1'b0));
        steps.push_back(mk("t5short", TXN_SETUP, 4'd7, sp(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0012), 1'b0, STAGE_STALLED, 1'b0, 7'h2A, 1'b0));
        steps.push_back(mk("t5setAddr", TXN_SETUP, 4'd8, sp(8'h00, 8'h05, 16'h0033, 16'h0000, 16'h0000), 1'b0, STAGE_STATUS_IN, 1'b1, 7'h2A, 1'b0));
        steps.push_back(mk("t5classOut", TXN_SETUP, 4'd8, sp(8'h21, 8'h09, 16'h0000, 16'h0000, 16'h0010), 1'b0, STAGE_DATA_OUT, 1'b1, 7'h2A, 1'b0));
        steps.push_back(mk("t5out8", TXN_OUT, 4'd8, 64'h1122334455667788, 1'b0, STAGE_DATA_OUT, 1'b0, 7'h2A, 1'b1));
        steps.push_back(mk("t5abort", TXN_SETUP, 4'd8, sp(8'h40, 8'h01, 16'h0000, 16'h0000, 16'h0000), 1'b0, STAGE_STATUS_IN, 1'b1, 7'h2A, 1'b0));
        steps.push_back(mk("t5noAddr", TXN_IN, 4'd0, 64'h0, 1'b0, STAGE_IDLE, 1'b0, 7'h2A, 1'b0));
        steps.push_back(mk("setCfg", TXN_SETUP, 4'd8, sp(8'h00, 8'h09, 16'h0003, 16'h0000, 16'h0000), 1'b0, STAGE_STATUS_IN, 1'b1, 7'h2A, 1'b0));
        steps.push_back(mk("setCfgSt", TXN_IN, 4'd0, 64'h0, 1'b0, STAGE_IDLE, 1'b0, 7'h2A, 1'b0));
        steps.push_back(mk("ovrSetup", TXN_SETUP, 4'd8, sp(8'h21, 8'h01, 16'h0000, 16'h0000, 16'h0004), 1'b0, STAGE_DATA_OUT, 1'b1, 7'h2A, 1'b0));
        steps.push_back(mk("ovrOut6", TXN_OUT, 4'd6, 64'h0000CAFEBABE0102, 1'b0, STAGE_STALLED, 1'b0, 7'h2A, 1'b1));
        steps.push_back(mk("gsSetup", TXN_SETUP, 4'd8, sp(8'h80, 8'h00, 16'h0000, 16'h0000, 16'h0002), 1'b0, STAGE_DATA_IN, 1'b1, 7'h2A, 1'b0));
        steps.push_back(mk("gsIn2", TXN_IN, 4'd2, 64'h0, 1'b0, STAGE_STATUS_OUT, 1'b0, 7'h2A, 1'b0));
        steps.push_back(mk("gsBadStatus", TXN_OUT, 4'd1, 64'h0, 1'b1, STAGE_STALLED, 1'b0, 7'h2A, 1'b0));
        steps.push_back(mk("esSetup", TXN_SETUP, 4'd8, sp(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0040), 1'b0, STAGE_DATA_IN, 1'b1, 7'h2A, 1'b0));
        steps.push_back(mk("esEarlyOut", TXN_OUT, 4'd0, 64'h0, 1'b0, STAGE_IDLE, 1'b0, 7'h2A, 1'b0));
        steps.push_back(mk("illegalTxn", 3'b011, 4'd0, 64'h0, 1'b0, STAGE_IDLE, 1'b0, 7'h2A, 1'b0));

        foreach (steps[i]) begin
            doTxn(steps[i].name, steps[i].txn, steps[i].nb, steps[i].data, steps[i].expStall, steps[i].push, w);
            check({steps[i].name, ".stage"}, 64'(o_stage), 64'(steps[i].expStage));
            check({steps[i].name, ".req"}, 64'(o_reqValid), 64'(steps[i].expReq));
            check({steps[i].name, ".addr"}, 64'(o_addr), 64'(steps[i].expAddr));
        end
        check("cfgApplied", 64'(o_cfg), 64'h03);
        check("fields", {o_bmRequestType, o_bRequest, o_wValue, o_wIndex, o_wLength[7:0]}, 64'h8006_0100_0000_40);

        // Back-pressure: the second OUT waits until the sink drains the first packet.
        doTxn("t3setup", TXN_SETUP, 4'd8, sp(8'h21, 8'h09, 16'h0000, 16'h0000, 16'd10), 1'b0, 1'b0, w);
        check("t3setup.stage", 64'(o_stage), 64'(STAGE_DATA_OUT));
        @(posedge i_clk); #1;
        outReady = 1'b0;
        doTxn("t3out8", TXN_OUT, 4'd8, 64'hA1A2A3A4A5A6A7A8, 1'b0, 1'b1, w);
        check("t3out8.stage", 64'(o_stage), 64'(STAGE_DATA_OUT));
        check("t3out8.valid", 64'(o_outValid), 64'd1);
        fork
            doTxn("t3out2", TXN_OUT, 4'd2, 64'h000000000000B1B2, 1'b0, 1'b1, w);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge i_clk);
                    check("t3readyLow", 64'(erIf.erReady), 64'd0);
                end
                @(posedge i_clk); #1;
                outReady = 1'b1;
            end
        join
        check("t3waited", 64'(w >= 4), 64'd1);
        check("t3out2.stage", 64'(o_stage), 64'(STAGE_STATUS_IN));
        repeat (3) @(negedge i_clk);
        check("t3drained", 64'(sbQ.size()), 64'd0);

        // Asynchronous reset with a full buffer mid DATA_OUT.
        doTxn("t6setup", TXN_SETUP, 4'd8, sp(8'h21, 8'h09, 16'h0000, 16'h0000, 16'h0010), 1'b0, 1'b0, w);
        @(posedge i_clk); #1;
        outReady = 1'b0;
        doTxn("t6out8", TXN_OUT, 4'd8, 64'h0F0E0D0C0B0A0908, 1'b0, 1'b1, w);
        check("t6full", 64'(o_outValid), 64'd1);
        @(posedge i_clk); #3;
        erIf.erValid = 1'b1;
        erIf.txnType = TXN_IN;
        i_rst = 1'b0;
        #1;
        check("t6.ready", 64'(erIf.erReady), 64'd0);
        check("t6.stall", 64'(erIf.erStall), 64'd0);
        check("t6.stage", 64'(o_stage), 64'(STAGE_IDLE));
        check("t6.outValid", 64'(o_outValid), 64'd0);
        check("t6.outData", o_outData, 64'd0);
        check("t6.nBytes", 64'(o_outData_nBytes), 64'd0);
        check("t6.addrCfg", 64'({o_addr, o_cfg}), 64'd0);
        check("t6.fields", 64'({o_reqValid, o_bmRequestType, o_bRequest, o_wValue, o_wLength}), 64'd0);
        sbQ.delete();
        erIf.erValid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        outReady = 1'b1;
        doTxn("t6post", TXN_SETUP, 4'd8, sp(8'h80, 8'h06, 16'h0100, 16'h0000, 16'h0012), 1'b0, 1'b0, w);
        check("t6post.stage", 64'(o_stage), 64'(STAGE_DATA_IN));
        check("t6post.req", 64'(o_reqValid), 64'd1);
        check("t6post.addrCfg", 64'({o_addr, o_cfg}), 64'd0);

        repeat (2) @(negedge i_clk);
        check("sbEmpty", 64'(sbQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/usb_ctrl_ep_rx.md
Name: usb_ctrl_ep_rx

Overview:
Synthesizable control-endpoint (EP0) receive stage. It sits directly downstream of the full-speed transaction layer's endpoint-receive handshake (o_erReady/i_erValid/i_erData/i_erData_nBytes/i_txnType/o_erStall) and replaces the bench-only endpoint driver in real designs. It decodes SETUP packets and tracks control-transfer stages. It forwards OUT data-stage payload to a sink through a one-entry buffer, applies SET_ADDRESS and SET_CONFIGURATION, and issues STALL for illegal or unsupported traffic.

Parameters:
MAX_PKT, 8, max packet bytes; must be >= 8 (SETUP is 8 bytes).

Ports:
i_clk  in  1  clock
i_rst  in  1  reset; active-low, asynchronous assert, synchronous deassert upstream
o_erStall  out  1  STALL response for the transaction being accepted
o_erReady  out  1  ready for endpoint-rx handshake
i_erValid  in  1  endpoint-rx valid
i_erData  in  8*MAX_PKT  packet payload, byte 0 in [7:0]
i_erData_nBytes  in  $clog2(MAX_PKT)+1  payload byte count
i_txnType  in  3  one-hot {SETUP, OUT, IN}; IN = host ACKed a device IN packet of nBytes
o_reqValid  out  1  one-cycle pulse per valid, unstalled SETUP
o_bmRequestType  out  8  latched request fields, stable until next SETUP
o_bRequest  out  8
o_wValue  out  16
o_wIndex  out  16
o_wLength  out  16
o_stage  out  3  IDLE=0 DATA_OUT=1 DATA_IN=2 STATUS_OUT=3 STATUS_IN=4 STALLED=5
o_outValid  out  1  buffered OUT data-stage packet valid
i_outReady  in  1  sink ready
o_outData  out  8*MAX_PKT  buffered payload
o_outData_nBytes  out  $clog2(MAX_PKT)+1
o_addr  out  7  device address
o_cfg  out  8  current configuration value

Behaviour:
- Accept = o_erReady && i_erValid. All state updates occur on accept edges only.
- Reset (i_rst low) forces the following, regardless of mid-transfer state: stage=IDLE, all outputs 0, o_addr=0, o_cfg=0, remaining=0, pendAddr cleared, buffer empty.
- o_erReady:
  - 1 when i_txnType[2] (SETUP), so SETUP is never back-pressured.
  - For OUT while stage=DATA_OUT: !o_outValid || i_outReady.
  - 1 otherwise.
- o_erStall (combinational, meaningful only on accept):
  - Never asserted for SETUP.
  - Asserted when stage=STALLED.
  - Asserted for OUT when stage is not DATA_OUT/STATUS_OUT.
  - Asserted for IN when stage is not DATA_IN/STATUS_IN.
  - Asserted for STATUS_OUT with nBytes!=0.
- SETUP accept, from any stage (aborts an in-progress transfer and drops any pending address):
  - nBytes!=8 -> STALLED; no o_reqValid.
  - Latch fields. Type=Standard (bits[6:5]=0) with bRequest not in {GET_STATUS, CLEAR_FEATURE, SET_ADDRESS, GET_DESCRIPTOR, GET_CONFIGURATION, SET_CONFIGURATION} -> STALLED; no o_reqValid.
  - Otherwise: o_reqValid=1 on the next cycle, and remaining=wLength.
  - Next stage: wLength=0 -> STATUS_IN. Direction=1 -> DATA_IN. Else DATA_OUT.
  - SET_ADDRESS: pendAddr=wValue[6:0].
  - SET_CONFIGURATION: o_cfg=wValue[7:0], applied immediately.
- DATA_OUT, OUT accept:
  - Payload and nBytes load into the buffer; o_outValid=1 next cycle.
  - remaining -= nBytes, saturating at 0; 16-bit, nBytes zero-extended.
  - nBytes>remaining -> STALLED; the packet is still buffered.
  - Go to STATUS_IN when the new remaining=0 or nBytes<MAX_PKT (short packet).
- Buffer: cleared on o_outValid && i_outReady. Load and drain in the same cycle is allowed; the new packet wins.
- DATA_IN, IN accept: remaining saturating-minus nBytes. When the new remaining=0 or nBytes<MAX_PKT -> STATUS_OUT. An OUT accepted in DATA_IN with nBytes=0 is an early status: -> IDLE, not stalled.
- STATUS_IN, IN accept: -> IDLE. If pendAddr is valid, o_addr=pendAddr on the following cycle and pendAddr is cleared.
- STATUS_OUT, OUT accept, nBytes=0: -> IDLE.
- STALLED: holds until the next SETUP.
- Illegal i_txnType (not one-hot): ignored; no state change; stall=0.

Decomposition:
- Shared package usbSpec: BREQUEST_* codes, bmRequestType field offsets, stage encoding constants.
- One sub-module, usb_ctrl_skid1: a single-entry valid/ready buffer of width 8*MAX_PKT+$clog2(MAX_PKT)+1.

Test Plan:
1. SETUP 80_06_0100_0000_0012 (GET_DESCRIPTOR, wLength=18), then IN nBytes 8,8,2, then zero-length OUT. Required: o_reqValid pulse once; stages DATA_IN,DATA_IN,STATUS_OUT,IDLE; no stall.
2. SET_ADDRESS wValue=0x2A. Required: o_addr stays 0 through the SETUP accept and after the status IN; it becomes 0x2A the cycle after the status IN accept.
3. Host-to-device class SETUP, wLength=10. Then OUT 8 bytes with i_outReady=0 for 5 cycles; o_erReady must stay low for the second OUT until the drain. Then OUT 2 bytes -> STATUS_IN. Sink sees payloads of 8 then 2 bytes.
4. Standard bRequest=0x0C (SYNCH_FRAME, unsupported), then OUT and IN. Required: both stalled; a following valid SETUP clears STALLED and is not stalled.
5. SETUP with nBytes=7 -> STALLED, no o_reqValid. Then SETUP mid DATA_OUT aborts cleanly; a pending SET_ADDRESS is discarded.
6. Assert i_rst low during DATA_OUT with the buffer full. Required: all outputs 0 asynchronously; o_addr and o_cfg reset; first post-reset SETUP is accepted normally.
